// File: rtl/udp_checksum_ctrl_pkg.sv
// Shared types and constants for the UDP checksum verification sequencer.
package udp_csum_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        FOLD1,
        FOLD2,
        DONE
    } state_t;

    localparam logic [15:0] CSUM_NEG_ZERO         = 16'hFFFF;
    localparam int          IPV4_PSEUDO_HDR_WORDS = 6;

endpackage

// File: rtl/udp_checksum_ctrl_fold.sv
// One end-around-carry fold of the wide accumulator into its low half.
module ones_comp_fold #(
    parameter int ACC_W = 32
) (
    input  logic [ACC_W-1:0] acc,
    output logic [ACC_W-1:0] folded
);

    assign folded = ACC_W'(acc[15:0]) + ACC_W'(acc[ACC_W-1:16]);

endmodule

// File: rtl/udp_checksum_ctrl.sv
// UDP checksum sequencer: accumulate words, fold twice, report sum/pass.
// Optional UDP_CSUM_ZERO_BYPASS_EN: a zero checksum field forces a pass.
module udp_checksum_ctrl
    import udp_csum_pkg::*;
#(
    parameter int LEN_W         = 16,
    parameter int ACC_W         = 32,
    parameter int CSUM_WORD_IDX = IPV4_PSEUDO_HDR_WORDS + 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len_words,
    input  logic             i_word_valid,
    input  logic [15:0]      i_word,
    output logic             o_word_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic [15:0]      o_sum,
    output logic             o_checksum_ok,
    output logic             o_len_err
);

    state_t             state_q;
    state_t             state_d;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   fold_out;
    logic [LEN_W-1:0]   count_q;
    logic               xfer;
    logic               len_zero;

`ifdef UDP_CSUM_ZERO_BYPASS_EN
    localparam int IDX_W = $clog2(CSUM_WORD_IDX + 2);
    logic [IDX_W-1:0]   idx_q;
    logic               bypass_q;
`endif

    ones_comp_fold #(
        .ACC_W (ACC_W)
    ) u_fold (
        .acc    (acc_q),
        .folded (fold_out)
    );

    assign xfer     = i_word_valid && o_word_ready;
    assign len_zero = (i_len_words == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        o_busy       = (state_q != IDLE);
        o_word_ready = (state_q == ACCUM);
        o_done       = (state_q == DONE);
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = len_zero ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (xfer && count_q == LEN_W'(1)) begin
                    state_d = FOLD1;
                end
            end
            FOLD1:   state_d = FOLD2;
            FOLD2:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q         <= '0;
            count_q       <= '0;
            o_sum         <= '0;
            o_checksum_ok <= 1'b0;
            o_len_err     <= 1'b0;
`ifdef UDP_CSUM_ZERO_BYPASS_EN
            idx_q         <= '0;
            bypass_q      <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_start) begin
`ifdef UDP_CSUM_ZERO_BYPASS_EN
                        idx_q    <= '0;
                        bypass_q <= 1'b0;
`endif
                        if (len_zero) begin
                            o_len_err     <= 1'b1;
                            o_sum         <= '0;
                            o_checksum_ok <= 1'b0;
                        end else begin
                            count_q <= i_len_words;
                            acc_q   <= '0;
                        end
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        acc_q   <= acc_q + ACC_W'(i_word);
                        count_q <= count_q - LEN_W'(1);
`ifdef UDP_CSUM_ZERO_BYPASS_EN
                        if (idx_q != IDX_W'(CSUM_WORD_IDX + 1)) begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                        if (idx_q == IDX_W'(CSUM_WORD_IDX) && i_word == 16'h0000) begin
                            bypass_q <= 1'b1;
                        end
`endif
                    end
                end
                FOLD1: begin
                    acc_q <= fold_out;
                end
                FOLD2: begin
                    // Results are registered here so they are valid during DONE.
                    acc_q     <= fold_out;
                    o_sum     <= fold_out[15:0];
                    o_len_err <= 1'b0;
`ifdef UDP_CSUM_ZERO_BYPASS_EN
                    o_checksum_ok <= (fold_out[15:0] == CSUM_NEG_ZERO) || bypass_q;
`else
                    o_checksum_ok <= (fold_out[15:0] == CSUM_NEG_ZERO);
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_checksum_ctrl.sv
// Self-checking bench for udp_checksum_ctrl: vector table plus random packets.
module tb_udp_checksum_ctrl;

    logic        i_clk;
    logic        i_rst;
    logic        i_start;
    logic [15:0] i_len_words;
    logic        i_word_valid;
    logic [15:0] i_word;
    logic        o_word_ready;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_sum;
    logic        o_checksum_ok;
    logic        o_len_err;

    int checks = 0;
    int errors = 0;

    logic [15:0] pkt[$];

    typedef struct {
        int          len;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] w2;
        int          mode;
        bit          glitch;
        logic [15:0] exp_sum;
        bit          exp_ok;
        bit          exp_lerr;
    } vec_t;

    vec_t vecs[$];

    udp_checksum_ctrl dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_len_words   (i_len_words),
        .i_word_valid  (i_word_valid),
        .i_word        (i_word),
        .o_word_ready  (o_word_ready),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_sum         (o_sum),
        .o_checksum_ok (o_checksum_ok),
        .o_len_err     (o_len_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One's-complement sum via modular arithmetic; nonzero multiples of 65535 are negative zero.
    function automatic logic [15:0] model_sum();
        longint s = 0;
        longint r;
        foreach (pkt[i]) s += pkt[i];
        if (s == 0) return 16'h0000;
        r = s % 65535;
        return (r == 0) ? 16'hFFFF : 16'(r);
    endfunction

    function automatic bit model_ok(input logic [15:0] s);
        bit ok = (s == 16'hFFFF);
`ifdef UDP_CSUM_ZERO_BYPASS_EN
        if (pkt.size() > 9 && pkt[9] == 16'h0000) ok = 1'b1;
`endif
        return ok;
    endfunction

    task automatic add_vec(input int len, input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2, input int mode, input bit glitch,
                           input logic [15:0] es, input bit eok, input bit elerr);
        vec_t v;
        v.len = len; v.w0 = w0; v.w1 = w1; v.w2 = w2;
        v.mode = mode; v.glitch = glitch;
        v.exp_sum = es; v.exp_ok = eok; v.exp_lerr = elerr;
        vecs.push_back(v);
    endtask

    // mode 0: valid every cycle, 1: every other cycle, 2: random.
    task automatic run_packet(input string tag, input int mode, input bit glitch,
                              input logic [15:0] es, input bit eok, input bit elerr);
        int  len  = pkt.size();
        int  idx  = 0;
        int  last = -1;
        int  cyc  = 0;
        bit  seen = 0;
        bit  v;
        @(negedge i_clk);
        i_start     = 1'b1;
        i_len_words = 16'(len);
        @(negedge i_clk);
        i_start = 1'b0;
        while (cyc < 2000) begin
            if (o_done) begin
                seen = 1;
                break;
            end
            i_start = glitch && (cyc == 1);
            if (glitch && cyc == 1) i_len_words = 16'd0;
            if (idx < len) begin
                unique case (mode)
                    0:       v = 1'b1;
                    1:       v = (cyc % 2 == 1);
                    default: v = 1'($urandom_range(0, 1));
                endcase
                i_word_valid = v;
                i_word       = v ? pkt[idx] : 16'($urandom);
                if (v && o_word_ready) begin
                    idx++;
                    last = cyc;
                end
            end else begin
                i_word_valid = 1'b0;
                i_word       = 16'($urandom);
            end
            @(negedge i_clk);
            cyc++;
        end
        i_start      = 1'b0;
        i_word_valid = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s done_timeout: got no o_done, expected pulse", tag);
            return;
        end
        if (len == 0) chk({tag, " start_to_done"}, cyc, 0);
        else          chk({tag, " latency"}, cyc - last, 3);
        chk({tag, " sum"}, o_sum, es);
        chk({tag, " ok"}, o_checksum_ok, eok);
        chk({tag, " len_err"}, o_len_err, elerr);
        chk({tag, " busy_in_done"}, o_busy, 1);
        @(negedge i_clk);
        chk({tag, " done_one_cycle"}, o_done, 0);
        chk({tag, " idle_after"}, o_busy, 0);
        chk({tag, " sum_held"}, o_sum, es);
    endtask

    initial begin
        logic [15:0] es;
        i_rst        = 1'b1;
        i_start      = 1'b0;
        i_len_words  = '0;
        i_word_valid = 1'b0;
        i_word       = '0;
        repeat (2) @(negedge i_clk);
        chk("rst busy",   o_busy, 0);
        chk("rst done",   o_done, 0);
        chk("rst ready",  o_word_ready, 0);
        chk("rst sum",    o_sum, 0);
        chk("rst ok",     o_checksum_ok, 0);
        chk("rst lenerr", o_len_err, 0);
        i_rst = 1'b0;

        add_vec(2, 16'h1234, 16'hEDCB, 16'h0000, 0, 0, 16'hFFFF, 1, 0);
        add_vec(3, 16'h8000, 16'h8000, 16'hFFFE, 0, 0, 16'hFFFF, 1, 0);
        add_vec(3, 16'h8000, 16'h8000, 16'hFFFD, 0, 0, 16'hFFFE, 0, 0);
        add_vec(2, 16'h1234, 16'hEDCB, 16'h0000, 1, 0, 16'hFFFF, 1, 0);
        add_vec(0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 1);
        add_vec(2, 16'h1234, 16'hEDCB, 16'h0000, 0, 1, 16'hFFFF, 1, 0);
        add_vec(1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0);
        add_vec(2, 16'hFFFF, 16'hFFFF, 16'h0000, 0, 0, 16'hFFFF, 1, 0);
        add_vec(3, 16'h0001, 16'h0002, 16'h0003, 1, 0, 16'h0006, 0, 0);

        foreach (vecs[i]) begin
            pkt.delete();
            if (vecs[i].len > 0) pkt.push_back(vecs[i].w0);
            if (vecs[i].len > 1) pkt.push_back(vecs[i].w1);
            if (vecs[i].len > 2) pkt.push_back(vecs[i].w2);
            run_packet($sformatf("vec%0d", i), vecs[i].mode, vecs[i].glitch,
                       vecs[i].exp_sum, vecs[i].exp_ok, vecs[i].exp_lerr);
        end

        // Reset in the middle of a packet, then a clean packet.
        @(negedge i_clk);
        i_start     = 1'b1;
        i_len_words = 16'd2;
        @(negedge i_clk);
        i_start      = 1'b0;
        i_word_valid = 1'b1;
        i_word       = 16'h1111;
        @(negedge i_clk);
        i_word_valid = 1'b0;
        i_rst        = 1'b1;
        repeat (2) @(negedge i_clk);
        chk("midrst busy",  o_busy, 0);
        chk("midrst ready", o_word_ready, 0);
        chk("midrst sum",   o_sum, 0);
        i_rst = 1'b0;
        pkt.delete();
        pkt.push_back(16'h1234);
        pkt.push_back(16'hEDCB);
        run_packet("after_rst", 0, 0, 16'hFFFF, 1, 0);

        // 12-word packet whose checksum field is zero and whose sum is not negative zero.
        pkt.delete();
        for (int k = 0; k < 12; k++) pkt.push_back(16'(k + 1));
        pkt[9] = 16'h0000;
        es = model_sum();
        run_packet("zero_csum", 0, 0, es, model_ok(es), 0);

        for (int n = 0; n < 25; n++) begin
            int len = $urandom_range(1, 20);
            pkt.delete();
            for (int k = 0; k < len; k++) pkt.push_back(16'($urandom));
            if (n % 4 == 0 && len > 9) pkt[9] = 16'h0000;
            if (n % 5 == 1) begin
                // Patch the final word so the total is a multiple of 65535.
                longint s = 0;
                for (int k = 0; k < len - 1; k++) s += pkt[k];
                pkt[len-1] = 16'(65535 - (s % 65535));
            end
            es = model_sum();
            run_packet($sformatf("rnd%0d", n), 2, 0, es, model_ok(es), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
